// File: rtl/dsc_pkg.sv
// Shared types for the deterministic stochastic-computing (DSC) datapath.
//   SN_LEN_LOG2   : log2 of the full stream length at the default operand width
//   dsc_state_t   : stream generator FSM states
//   dsc_operand_t : operand pair at the default width
package dsc_pkg;
  localparam int DSC_NUM_BITS = 8;
  localparam int SN_LEN_LOG2  = 2 * DSC_NUM_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsc_state_t;

  typedef struct packed {
    logic [DSC_NUM_BITS-1:0] a;
    logic [DSC_NUM_BITS-1:0] b;
  } dsc_operand_t;
endpackage

// File: rtl/dsc_sn_gen_prg.sv
// prg_nb: NUM_BITS up-counter plus comparator, one per unary stream.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : clear counter (operand accept)
//   adv          : advance counter this cycle
//   val          : operand compared against the counter
//   sn           : stochastic bit (val > ctr), combinational
//   ctr          : current counter value
//   ctr_overflow : counter wraps max -> 0 on this cycle
module prg_nb #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  input  logic [NUM_BITS-1:0] val,
  output logic                sn,
  output logic [NUM_BITS-1:0] ctr,
  output logic                ctr_overflow
);
  localparam logic [NUM_BITS-1:0] CTR_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) ctr <= '0;
    else if (adv)   ctr <= ctr + 1'b1;
  end

  assign sn           = (val > ctr);
  assign ctr_overflow = adv && (ctr == CTR_MAX);
endmodule

// File: rtl/dsc_sn_gen.sv
// dsc_sn_gen: transmit side of the 2-input serial DSC datapath. Operands are
// accepted on a valid/ready handshake and turned into two unary streams using
// clock division: the a-counter runs every active cycle, the b-counter steps
// once per a-counter wrap, so AND-ing the streams yields exactly a*b ones.
//   clk, rst          : clock, synchronous active-high reset
//   en                : advance enable (low stalls the stream)
//   in_valid/in_ready : operand handshake
//   a, b              : unsigned operands
//   sn_a, sn_b        : stochastic bits, qualified by sn_valid
//   sn_last           : final bit of the stream, qualified by sn_valid
//   busy              : stream in progress
module dsc_sn_gen
  import dsc_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int EARLY_TERM = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                sn_a,
  output logic                sn_b,
  output logic                sn_valid,
  output logic                sn_last,
  output logic                busy
);
  localparam logic [NUM_BITS-1:0] CTR_MAX = '1;

  dsc_state_t          state;
  logic [NUM_BITS-1:0] a_q, b_q;
  logic [NUM_BITS-1:0] ctr_a, ctr_b;
  logic                sn_a_c, sn_b_c, ovf_a, ovf_b;
  logic                accept, active, clr, last_hit;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign clr    = accept;
  // sn_last already out means the stream is done: freeze counters for the
  // single wind-down cycle before returning to IDLE.
  assign active = (state == RUN) && en && !sn_last;

  prg_nb #(.NUM_BITS(NUM_BITS)) u_prg_a (
    .clk(clk), .rst(rst), .clr(clr), .adv(active), .val(a_q),
    .sn(sn_a_c), .ctr(ctr_a), .ctr_overflow(ovf_a)
  );

  prg_nb #(.NUM_BITS(NUM_BITS)) u_prg_b (
    .clk(clk), .rst(rst), .clr(clr), .adv(ovf_a), .val(b_q),
    .sn(sn_b_c), .ctr(ctr_b), .ctr_overflow(ovf_b)
  );

  // End of stream is decided from counter values only.
  generate
    if (EARLY_TERM != 0) begin : g_early
      // Zero operand contributes nothing: one all-zero bit closes the stream.
      // Otherwise stop after the last b-row that can still produce ones.
      assign last_hit = (a_q == '0) || (b_q == '0) ||
                        ((ctr_a == CTR_MAX) && (ctr_b == b_q - 1'b1));
    end else begin : g_full
      assign last_hit = (ctr_a == CTR_MAX) && (ctr_b == CTR_MAX);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      sn_a     <= 1'b0;
      sn_b     <= 1'b0;
      sn_valid <= 1'b0;
      sn_last  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (sn_last) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            sn_a     <= 1'b0;
            sn_b     <= 1'b0;
            sn_valid <= 1'b0;
            sn_last  <= 1'b0;
          end else begin
            sn_valid <= en;
            sn_a     <= en && sn_a_c;
            sn_b     <= en && sn_b_c;
            sn_last  <= en && last_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_ovf_b;
  assign unused_ovf_b = ovf_b;
endmodule
